decode_issue_arbiter: RTL and testbench

Shares the single dispatch port behind the decode stage among several instruction-format decoders. Each decoder's output (enable plus an opaque decoded payload whose leading bits hold the functional-unit code) is captured into a one-entry holding slot. A round-robin scheduler picks one eligible slot per cycle, skipping slots whose target functional unit is busy, and loads it into a registered output stage with valid/ready handshake to dispatch.

---
 rtl/decode_issue_arbiter.sv | 169 ++++++++++++++++
 tb/tb_decode_issue_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_arbiter.sv
// decode_issue_arbiter
//
// Shares one dispatch port among numReq instruction-format decoders. Each decoder
// writes into a one-entry holding slot. A round-robin scheduler picks one eligible
// slot per cycle and skips slots whose functional unit is busy. The chosen slot is
// loaded into a registered output stage that hands off to dispatch with valid/ready.
//
// Bit numbering: requester k uses enable_i[k], stall_o[k] and
// payload_i[k*payloadWidth +: payloadWidth]. The functional-unit code is held in
// payload bits [2:0].
//
// Ports
//   clock_i        rising-edge clock
//   reset_i        asynchronous, active-high reset
//   enable_i       per-decoder payload-valid strobe
//   payload_i      concatenated decoder payloads
//   stall_o        per-decoder back-pressure (combinational)
//   fuBusy_i       per-functional-unit busy lines
//   valid_o        output stage holds an instruction
//   ready_i        dispatch accepts the output stage
//   payload_o      granted payload
//   grantId_o      requester index of payload_o
//   issuedCount_o  wrapping count of dispatch handshakes
//   overflow_o     one-cycle pulse after an enable_i was dropped while stalled
module decode_issue_arbiter #(
  parameter int unsigned numReq       = 4,
  parameter int unsigned payloadWidth = 48,
  parameter int unsigned fuCount      = 5,
  parameter int unsigned idWidth      = 2
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [numReq-1:0]              enable_i,
  input  logic [numReq*payloadWidth-1:0] payload_i,
  output logic [numReq-1:0]              stall_o,
  input  logic [fuCount-1:0]             fuBusy_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [payloadWidth-1:0]        payload_o,
  output logic [idWidth-1:0]             grantId_o,
  output logic [15:0]                    issuedCount_o,
  output logic                           overflow_o
);

  localparam int unsigned FuCodeWidth = 3;

  logic [numReq-1:0]       slot_valid_q, slot_valid_d;
  logic [payloadWidth-1:0] slot_payload_q [numReq];
  logic [payloadWidth-1:0] slot_payload_d [numReq];
  logic [idWidth-1:0]      rr_ptr_q, rr_ptr_d;
  logic                    valid_q, valid_d;
  logic [payloadWidth-1:0] payload_q, payload_d;
  logic [idWidth-1:0]      grant_id_q, grant_id_d;
  logic [15:0]             issued_count_q, issued_count_d;
  logic                    overflow_q, overflow_d;

  logic [numReq-1:0]  eligible;
  logic [numReq-1:0]  drain;
  logic [idWidth-1:0] search_idx;
  logic [idWidth-1:0] grant_idx;
  logic               grant_found;
  logic               can_load;
  logic               grant;

  // Codes without a busy line (>= fuCount) are never blocked.
  function automatic logic fu_is_busy(input logic [FuCodeWidth-1:0] code,
                                      input logic [fuCount-1:0]     busy);
    logic result;
    result = 1'b0;
    for (int unsigned f = 0; f < fuCount; f++) begin
      if (32'(code) == f) result = busy[f];
    end
    return result;
  endfunction

  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < numReq; k++) begin
      eligible[k] = slot_valid_q[k] &
                    ~fu_is_busy(slot_payload_q[k][FuCodeWidth-1:0], fuBusy_i);
    end
  end

  // First eligible slot at or after rr_ptr_q; the index wraps because numReq is 2^idWidth.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    search_idx  = rr_ptr_q;
    for (int unsigned i = 0; i < numReq; i++) begin
      search_idx = rr_ptr_q + idWidth'(i);
      if (!grant_found && eligible[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  assign can_load = ~valid_q | ready_i;
  assign grant    = grant_found & can_load;

  always_comb begin
    drain = '0;
    for (int unsigned k = 0; k < numReq; k++) begin
      drain[k] = grant && (grant_idx == idWidth'(k));
    end
  end

  assign stall_o = slot_valid_q & ~drain;

  // Slot capture/drain. A drained slot may be refilled in the same cycle.
  always_comb begin
    slot_valid_d = slot_valid_q;
    for (int unsigned k = 0; k < numReq; k++) begin
      slot_payload_d[k] = slot_payload_q[k];
      if (enable_i[k] && !stall_o[k]) begin
        slot_valid_d[k]   = 1'b1;
        slot_payload_d[k] = payload_i[k*payloadWidth +: payloadWidth];
      end else if (drain[k]) begin
        slot_valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    valid_d        = valid_q;
    payload_d      = payload_q;
    grant_id_d     = grant_id_q;
    rr_ptr_d       = rr_ptr_q;
    issued_count_d = issued_count_q + {15'd0, valid_q & ready_i};
    overflow_d     = |(enable_i & stall_o);
    if (grant) begin
      valid_d    = 1'b1;
      payload_d  = slot_payload_q[grant_idx];
      grant_id_d = grant_idx;
      rr_ptr_d   = grant_idx + idWidth'(1);
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      slot_valid_q   <= '0;
      for (int unsigned k = 0; k < numReq; k++) slot_payload_q[k] <= '0;
      rr_ptr_q       <= '0;
      valid_q        <= 1'b0;
      payload_q      <= '0;
      grant_id_q     <= '0;
      issued_count_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      slot_valid_q   <= slot_valid_d;
      slot_payload_q <= slot_payload_d;
      rr_ptr_q       <= rr_ptr_d;
      valid_q        <= valid_d;
      payload_q      <= payload_d;
      grant_id_q     <= grant_id_d;
      issued_count_q <= issued_count_d;
      overflow_q     <= overflow_d;
    end
  end

  assign valid_o       = valid_q;
  assign payload_o     = payload_q;
  assign grantId_o     = grant_id_q;
  assign issuedCount_o = issued_count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_decode_issue_arbiter.sv
// Randomized and directed bench for decode_issue_arbiter. A behavioural model
// holds the slots, output stage, pointer and counter as plain integers and arrays.
// The model predicts the outputs for every cycle.
module tb_decode_issue_arbiter;

  localparam int NR = 4;
  localparam int PW = 48;
  localparam int FC = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic [NR-1:0]  enable;
  logic [NR*PW-1:0] payload_in;
  logic [NR-1:0]  stall;
  logic [FC-1:0]  fu_busy;
  logic           valid;
  logic           ready;
  logic [PW-1:0]  payload_out;
  logic [1:0]     grant_id;
  logic [15:0]    issued_count;
  logic           overflow;

  decode_issue_arbiter #(
    .numReq(NR), .payloadWidth(PW), .fuCount(FC), .idWidth(2)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .enable_i     (enable),
    .payload_i    (payload_in),
    .stall_o      (stall),
    .fuBusy_i     (fu_busy),
    .valid_o      (valid),
    .ready_i      (ready),
    .payload_o    (payload_out),
    .grantId_o    (grant_id),
    .issuedCount_o(issued_count),
    .overflow_o   (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid [NR];
  logic [PW-1:0] m_pay [NR];
  int          m_ptr;
  bit          m_oval;
  logic [PW-1:0] m_opay;
  int          m_oid;
  int          m_cnt;
  bit          m_ovf;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      m_valid[k] = 1'b0;
      m_pay[k]   = '0;
    end
    m_ptr = 0; m_oval = 1'b0; m_opay = '0; m_oid = 0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  function automatic logic [PW-1:0] rand_pay(input int code);
    logic [PW-1:0] p;
    logic [31:0]   c;
    p      = {$urandom, $urandom};
    c      = code;
    p[2:0] = c[2:0];
    return p;
  endfunction

  // One clock: drive at negedge, check against model, advance model at posedge.
  task automatic step(input logic [NR-1:0] en, input logic [NR*PW-1:0] pl,
                      input logic [FC-1:0] busy, input bit rdy);
    int          g;
    bit          can_load;
    logic [NR-1:0] exp_stall;
    @(negedge clock);
    enable = en; payload_in = pl; fu_busy = busy; ready = rdy;
    #1;
    can_load = !m_oval || rdy;
    g = -1;
    if (can_load) begin
      for (int i = 0; i < NR; i++) begin
        int k;
        int code;
        k    = (m_ptr + i) % NR;
        code = int'(m_pay[k][2:0]);
        if (g < 0 && m_valid[k] && (code >= FC || !busy[code])) g = k;
      end
    end
    for (int k = 0; k < NR; k++) exp_stall[k] = m_valid[k] && (g != k);
    check_val("stall", 64'(stall), 64'(exp_stall));
    check_val("valid", 64'(valid), 64'(m_oval));
    check_val("payload", 64'(payload_out), 64'(m_opay));
    check_val("grant_id", 64'(grant_id), 64'(m_oid));
    check_val("count", 64'(issued_count), 64'(m_cnt));
    check_val("overflow", 64'(overflow), 64'(m_ovf));
    @(posedge clock);
    if (m_oval && rdy) m_cnt = (m_cnt + 1) % 65536;
    m_ovf = |(en & exp_stall);
    if (g >= 0) begin
      m_oval = 1'b1; m_opay = m_pay[g]; m_oid = g; m_ptr = (g + 1) % NR;
    end else if (rdy) begin
      m_oval = 1'b0;
    end
    for (int k = 0; k < NR; k++) begin
      if (en[k] && !exp_stall[k]) begin
        m_valid[k] = 1'b1;
        m_pay[k]   = pl[k*PW +: PW];
      end else if (g == k) begin
        m_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enable = '0; payload_in = '0; fu_busy = '0; ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [NR*PW-1:0] pl;
    logic [PW-1:0]    p3a, p3c;
    int               iter;

    reset = 1'b1; enable = '0; payload_in = '0; fu_busy = '0; ready = 1'b0;
    model_reset();
    #1;
    check_val("rst_valid", 64'(valid), 64'd0);
    check_val("rst_stall", 64'(stall), 64'd0);
    check_val("rst_count", 64'(issued_count), 64'd0);
    do_reset();

    // Single request on slot 1, FU=2
    pl = '0; pl[1*PW +: PW] = rand_pay(2);
    step(4'b0010, pl, '0, 1'b1);
    step(4'b0000, '0, '0, 1'b1);
    #1;
    check_val("single_valid", 64'(valid), 64'd1);
    check_val("single_id", 64'(grant_id), 64'd1);
    check_val("single_pay", 64'(payload_out), 64'(pl[1*PW +: PW]));
    step(4'b0000, '0, '0, 1'b1);
    #1;
    check_val("single_count", 64'(issued_count), 64'd1);

    // Round robin across all four slots, then slots 1 and 3 only
    do_reset();
    for (int k = 0; k < NR; k++) pl[k*PW +: PW] = rand_pay(0);
    step(4'b1111, pl, '0, 1'b1);
    for (int k = 0; k < NR; k++) begin
      step(4'b0000, '0, '0, 1'b1);
      #1;
      check_val("rr_all_id", 64'(grant_id), 64'(k));
    end
    for (int k = 0; k < NR; k++) pl[k*PW +: PW] = rand_pay(1);
    step(4'b1010, pl, '0, 1'b1);
    step(4'b0000, '0, '0, 1'b1);
    #1; check_val("rr_13_a", 64'(grant_id), 64'd1);
    step(4'b1010, pl, '0, 1'b1);
    #1; check_val("rr_13_b", 64'(grant_id), 64'd3);
    step(4'b0000, '0, '0, 1'b1);
    #1; check_val("rr_13_c", 64'(grant_id), 64'd1);
    step(4'b0000, '0, '0, 1'b1);
    #1; check_val("rr_13_d", 64'(grant_id), 64'd3);

    // FU busy skip
    do_reset();
    pl = '0; pl[0 +: PW] = rand_pay(2); pl[PW +: PW] = rand_pay(0);
    step(4'b0011, pl, 5'b00100, 1'b1);
    step(4'b0000, '0, 5'b00100, 1'b1);
    #1; check_val("busy_skip_id", 64'(grant_id), 64'd1);
    step(4'b0000, '0, 5'b00000, 1'b1);
    #1; check_val("busy_wrap_id", 64'(grant_id), 64'd0);

    // Back-pressure, overflow, drain-and-refill
    do_reset();
    pl = '0; pl[0 +: PW] = rand_pay(0); p3a = rand_pay(3); pl[3*PW +: PW] = p3a;
    step(4'b1001, pl, '0, 1'b0);
    step(4'b0000, '0, '0, 1'b0);
    step(4'b0000, '0, '0, 1'b0);
    pl = '0; pl[3*PW +: PW] = rand_pay(3);
    step(4'b1000, pl, '0, 1'b0);
    #1; check_val("ovf_pulse", 64'(overflow), 64'd1);
    pl = '0; p3c = rand_pay(4); pl[3*PW +: PW] = p3c;
    step(4'b1000, pl, '0, 1'b1);
    #1; check_val("drain_old", 64'(payload_out), 64'(p3a));
    step(4'b0000, '0, '0, 1'b1);
    #1; check_val("refill_new", 64'(payload_out), 64'(p3c));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [FC-1:0] busy;
      for (int k = 0; k < NR; k++) pl[k*PW +: PW] = rand_pay($urandom_range(0, 7));
      for (int f = 0; f < FC; f++) busy[f] = ($urandom_range(0, 3) == 0);
      step(NR'($urandom_range(0, 15)), pl, busy, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-operation with slots 0 and 2 full and output valid
    for (int k = 0; k < NR; k++) pl[k*PW +: PW] = rand_pay(1);
    step(4'b0101, pl, '0, 1'b0);
    step(4'b0000, '0, '0, 1'b0);
    step(4'b0101, pl, '0, 1'b0);
    @(negedge clock);
    #2;
    reset = 1'b1; enable = '0; ready = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(valid), 64'd0);
    check_val("mid_rst_pay", 64'(payload_out), 64'd0);
    check_val("mid_rst_id", 64'(grant_id), 64'd0);
    check_val("mid_rst_count", 64'(issued_count), 64'd0);
    check_val("mid_rst_ovf", 64'(overflow), 64'd0);
    check_val("mid_rst_stall", 64'(stall), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Saturated traffic up to the counter wrap
    iter = 0;
    while (m_cnt != 16'hFFFF && iter < 70000) begin
      for (int k = 0; k < NR; k++) pl[k*PW +: PW] = rand_pay($urandom_range(0, 7));
      step(4'b1111, pl, '0, 1'b1);
      iter++;
    end
    #1;
    check_val("cnt_ffff", 64'(issued_count), 64'hFFFF);
    step(4'b1111, pl, '0, 1'b1);
    #1;
    check_val("cnt_wrap", 64'(issued_count), 64'h0000);
    step(4'b0000, '0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
